vga_80x60_scanner: RTL

//  Downstream consumer of the 80x60 framebuffer: generates 640x480@60Hz VGA timing on the Basys3
//  100 MHz clock, scans the framebuffer read port (RA2/RD2) in raster order with 8x8 pixel

---
 rtl/vga_timing_pkg.sv | 32 +++
 rtl/vga_pix_en.sv | 30 +++
 rtl/vga_80x60_scanner.sv | 99 +++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants, counter types
// and RGB332 to RGB444 colour expansion.
package vga_timing_pkg;

  localparam int CLK_DIV    = 4;
  localparam int H_VIS      = 640;
  localparam int H_FP       = 16;
  localparam int H_SYNC     = 96;
  localparam int H_BP       = 48;
  localparam int V_VIS      = 480;
  localparam int V_FP       = 10;
  localparam int V_SYNC     = 2;
  localparam int V_BP       = 33;
  localparam int SCALE_LOG2 = 3;

  localparam int H_TOTAL      = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int H_SYNC_START = H_VIS + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_TOTAL      = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int V_SYNC_START = V_VIS + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  typedef logic [9:0] hcnt_t;
  typedef logic [9:0] vcnt_t;

  function automatic logic [11:0] rgb332_to_444(
    input logic [7:0] c
  );
    return {c[7:5], c[7], c[4:2], c[4], c[1:0], c[1:0]};
  endfunction

endpackage

// File: rtl/vga_pix_en.sv
// Pixel-rate strobe: one-clock pulse every CLK_DIV
// system clocks, first pulse in the CLK_DIV-th cycle.
module vga_pix_en #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic pix_en
);

  localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] div_q;
  logic [W-1:0] div_d;

  always_comb begin
    pix_en = (div_q == LAST);
    div_d  = pix_en ? '0 : div_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/vga_80x60_scanner.sv
// Raster scanner for the 80x60 framebuffer: VGA timing,
// 8x8 replicated read addressing and registered DAC/sync.
module vga_80x60_scanner #(
  parameter int CLK_DIV    = vga_timing_pkg::CLK_DIV,
  parameter int H_VIS      = vga_timing_pkg::H_VIS,
  parameter int H_FP       = vga_timing_pkg::H_FP,
  parameter int H_SYNC     = vga_timing_pkg::H_SYNC,
  parameter int H_BP       = vga_timing_pkg::H_BP,
  parameter int V_VIS      = vga_timing_pkg::V_VIS,
  parameter int V_FP       = vga_timing_pkg::V_FP,
  parameter int V_SYNC     = vga_timing_pkg::V_SYNC,
  parameter int V_BP       = vga_timing_pkg::V_BP,
  parameter int SCALE_LOG2 = vga_timing_pkg::SCALE_LOG2
) (
  input  logic        CLK,
  input  logic        RST_N,
  output logic [12:0] RA2,
  input  logic [7:0]  RD2,
  output logic [11:0] VGA_RGB,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        FRAME_START
);

  import vga_timing_pkg::*;

  localparam hcnt_t H_VIS_C = hcnt_t'(H_VIS);
  localparam hcnt_t H_LAST  = hcnt_t'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam hcnt_t HS_BEG  = hcnt_t'(H_VIS + H_FP);
  localparam hcnt_t HS_END  = hcnt_t'(H_VIS + H_FP + H_SYNC);
  localparam vcnt_t V_VIS_C = vcnt_t'(V_VIS);
  localparam vcnt_t V_LAST  = vcnt_t'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam vcnt_t VS_BEG  = vcnt_t'(V_VIS + V_FP);
  localparam vcnt_t VS_END  = vcnt_t'(V_VIS + V_FP + V_SYNC);

  logic        pix_en;
  logic        visible;
  logic        h_last;
  logic        v_last;
  hcnt_t       hcnt_q, hcnt_d;
  vcnt_t       vcnt_q, vcnt_d;
  logic [11:0] rgb_q, rgb_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;

  vga_pix_en #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_en (
    .clk    (CLK),
    .rst_n  (RST_N),
    .pix_en (pix_en)
  );

  always_comb begin
    h_last  = (hcnt_q == H_LAST);
    v_last  = (vcnt_q == V_LAST);
    visible = (hcnt_q < H_VIS_C) && (vcnt_q < V_VIS_C);
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    rgb_d   = rgb_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    if (pix_en) begin
      hcnt_d = h_last ? '0 : hcnt_q + hcnt_t'(1);
      if (h_last) begin
        vcnt_d = v_last ? '0 : vcnt_q + vcnt_t'(1);
      end
      // colour and sync describe the same (pre-increment) slot
      rgb_d = visible ? rgb332_to_444(RD2) : '0;
      hs_d  = !((hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
      vs_d  = !((vcnt_q >= VS_BEG) && (vcnt_q < VS_END));
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      rgb_q  <= '0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      rgb_q  <= rgb_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
    end
  end

  assign RA2 = visible ?
    {vcnt_q[SCALE_LOG2 +: 6], hcnt_q[SCALE_LOG2 +: 7]} : '0;

  assign FRAME_START = pix_en && h_last && v_last;
  assign VGA_RGB     = rgb_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;

endmodule
